// File: rtl/seg7_scan.sv
// -----------------------------------------------------------------------------
// seg7_scan
//
// Multiplexed 7-segment display driver. One digit is selected per slot of
// PRESCALE clocks and the digits are visited 0..DIGITS-1 in turn. Each digit
// shows either a hex-decoded nibble or a raw segment byte, with a per-digit
// decimal point and blank. Brightness is a PWM duty within the slot. The first
// cycle of every slot is a dark guard cycle, so segment data never overlaps
// the switch from one anode to the next (anti-ghosting). All display inputs
// are copied into shadow registers once per frame, so a frame never mixes old
// and new values.
//
// Optional feature macro: SEG7_BLINK_EN
//   When defined, adds input 'blink' and parameter BLINK_FRAMES. A blink phase
//   toggles every BLINK_FRAMES completed frames. While the phase is 1, digits
//   with blink=1 are dark as if blanked.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   numbers    in   4*DIGITS  hex nibble per digit, digit i = numbers[4i+:4]
//   raw_segs   in   8*DIGITS  raw segment byte per digit, digit i = raw_segs[8i+:8]
//   raw_mode   in   1 = show raw_segs, 0 = decode numbers
//   dp         in   DIGITS    decimal point per digit
//   blank      in   DIGITS    1 = digit dark for its whole slot
//   brightness in   BRIGHT_W  PWM duty, all-ones = full
//   blink      in   DIGITS    (SEG7_BLINK_EN only) blink enable per digit
//   LED_BITS   out  DIGITS    anode selects, registered, pin polarity
//   LED        out  8         segments {dp,g,f,e,d,c,b,a}, registered, pin polarity
//   frame_tick out  1         one-cycle pulse on the first cycle of each frame
// -----------------------------------------------------------------------------
module seg7_scan #(
   parameter int DIGITS         = 8,
   parameter int PRESCALE       = 1024,
   parameter int BRIGHT_W       = 4,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1
`ifdef SEG7_BLINK_EN
   ,
   parameter int BLINK_FRAMES   = 64
`endif
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   numbers,
   input  logic [8*DIGITS-1:0]   raw_segs,
   input  logic                  raw_mode,
   input  logic [DIGITS-1:0]     dp,
   input  logic [DIGITS-1:0]     blank,
   input  logic [BRIGHT_W-1:0]   brightness,
`ifdef SEG7_BLINK_EN
   input  logic [DIGITS-1:0]     blink,
`endif
   output logic [DIGITS-1:0]     LED_BITS,
   output logic [7:0]            LED,
   output logic                  frame_tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);

   // XOR masks that turn active-high values into pin levels.
   localparam logic [DIGITS-1:0] AN_INV  = {DIGITS{AN_ACTIVE_LOW}};
   localparam logic [7:0]        SEG_INV = {8{SEG_ACTIVE_LOW}};

   // Scan counters
   logic [PW-1:0]       r_pre_cnt;
   logic [IW-1:0]       r_idx;
   logic                r_first_cyc;

   // Frame snapshot
   logic [4*DIGITS-1:0] r_numbers;
   logic [8*DIGITS-1:0] r_raw_segs;
   logic                r_raw_mode;
   logic [DIGITS-1:0]   r_dp;
   logic [DIGITS-1:0]   r_blank;
   logic [BRIGHT_W-1:0] r_bright;

   // Registered outputs, already at pin polarity
   logic [DIGITS-1:0]   r_led_bits;
   logic [7:0]          r_led;
   logic                r_frame_tick;

   logic                w_slot_end;
   logic                w_frame_end;
   logic                w_capture;
   logic [DIGITS-1:0]   w_blank_eff;
   logic [3:0]          w_nibble;
   logic [7:0]          w_raw;
   logic                w_dp_bit;
   logic                w_blank_bit;
   logic [6:0]          w_hex;
   logic [7:0]          w_seg;
   logic [BRIGHT_W-1:0] w_pre_lo;
   logic                w_lit;
   logic [DIGITS-1:0]   w_an_hot;
   logic [7:0]          w_seg_on;

   assign w_slot_end  = (r_pre_cnt == PRE_LAST);
   assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
   // The snapshot is taken on the edge that starts a new frame, and once right
   // after reset so the very first frame already has real data.
   assign w_capture   = r_first_cyc || w_frame_end;

   // ---------------------------------------------------------------- counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pre_cnt   <= '0;
         r_idx       <= '0;
         r_first_cyc <= 1'b1;
      end else begin
         r_first_cyc <= 1'b0;
         if (w_slot_end) begin
            r_pre_cnt <= '0;
            r_idx     <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
         end else begin
            r_pre_cnt <= r_pre_cnt + PW'(1);
         end
      end
   end

   // ---------------------------------------------------------------- snapshot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_numbers  <= '0;
         r_raw_segs <= '0;
         r_raw_mode <= 1'b0;
         r_dp       <= '0;
         r_blank    <= '0;
         r_bright   <= '0;
      end else if (w_capture) begin
         r_numbers  <= numbers;
         r_raw_segs <= raw_segs;
         r_raw_mode <= raw_mode;
         r_dp       <= dp;
         r_blank    <= blank;
         r_bright   <= brightness;
      end
   end

`ifdef SEG7_BLINK_EN
   localparam int BCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_FRAMES - 1);

   logic [BCW-1:0]    r_blink_cnt;
   logic              r_blink_phase;
   logic [DIGITS-1:0] r_blink;

   // Counting frame ends (one cycle ahead of frame_tick) makes the phase flip
   // exactly at a frame boundary, so a frame is never half blinked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_blink_cnt   <= '0;
         r_blink_phase <= 1'b0;
         r_blink       <= '0;
      end else begin
         if (w_capture) begin
            r_blink <= blink;
         end
         if (w_frame_end) begin
            if (r_blink_cnt == BLINK_LAST) begin
               r_blink_cnt   <= '0;
               r_blink_phase <= ~r_blink_phase;
            end else begin
               r_blink_cnt <= r_blink_cnt + BCW'(1);
            end
         end
      end
   end

   assign w_blank_eff = r_blank | (r_blink & {DIGITS{r_blink_phase}});
`else
   assign w_blank_eff = r_blank;
`endif

   // ---------------------------------------------------------- digit select
   always_comb begin
      w_nibble    = '0;
      w_raw       = '0;
      w_dp_bit    = 1'b0;
      w_blank_bit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_nibble    = r_numbers[4*i +: 4];
            w_raw       = r_raw_segs[8*i +: 8];
            w_dp_bit    = r_dp[i];
            w_blank_bit = w_blank_eff[i];
         end
      end
   end

   // Hex to segments, bit0 = a .. bit6 = g, active high.
   always_comb begin
      w_hex = 7'h00;
      case (w_nibble)
         4'h0: w_hex = 7'h3F;
         4'h1: w_hex = 7'h06;
         4'h2: w_hex = 7'h5B;
         4'h3: w_hex = 7'h4F;
         4'h4: w_hex = 7'h66;
         4'h5: w_hex = 7'h6D;
         4'h6: w_hex = 7'h7D;
         4'h7: w_hex = 7'h07;
         4'h8: w_hex = 7'h7F;
         4'h9: w_hex = 7'h6F;
         4'hA: w_hex = 7'h77;
         4'hB: w_hex = 7'h7C;
         4'hC: w_hex = 7'h39;
         4'hD: w_hex = 7'h5E;
         4'hE: w_hex = 7'h79;
         4'hF: w_hex = 7'h71;
      endcase
   end

   assign w_seg    = (r_raw_mode ? w_raw : {1'b0, w_hex}) | {w_dp_bit, 7'b000_0000};

   // PRESCALE >= 2**BRIGHT_W guarantees the counter is at least BRIGHT_W wide;
   // its low bits are the position within the PWM period.
   assign w_pre_lo = r_pre_cnt[BRIGHT_W-1:0];
   // pre_cnt == 0 is the guard cycle: the anode just changed, keep everything dark.
   assign w_lit    = !w_blank_bit && (r_pre_cnt != '0) && (w_pre_lo <= r_bright);
   assign w_an_hot = w_lit ? (DIGITS'(1) << r_idx) : '0;
   // Segments are only ever driven together with their anode.
   assign w_seg_on = w_lit ? w_seg : 8'h00;

   // ---------------------------------------------------------------- outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_led_bits   <= AN_INV;
         r_led        <= SEG_INV;
         r_frame_tick <= 1'b0;
      end else begin
         r_led_bits   <= w_an_hot ^ AN_INV;
         r_led        <= w_seg_on ^ SEG_INV;
         r_frame_tick <= w_frame_end;
      end
   end

   assign LED_BITS   = r_led_bits;
   assign LED        = r_led;
   assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan
//
// Bench for seg7_scan with DIGITS=4, PRESCALE=4, BRIGHT_W=2, both polarities
// active low. A reference model derives every output from the number of clock
// edges since reset and the input set captured at each frame start. Fixed
// vectors check per-digit patterns and lit-cycle counts over whole frames;
// hand-written sequences cover mid-frame input changes and reset mid-slot;
// a randomized phase is checked cycle by cycle against the model.
// -----------------------------------------------------------------------------
module tb_seg7_scan;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 4;
   localparam int BRIGHT_W = 2;
   localparam int FRAME    = DIGITS * PRESCALE;
   localparam int PWM_PER  = 2 ** BRIGHT_W;

   // ------------------------------------------------------ clock and reset
   logic clk;
   logic rst_n;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------ DUT i/o
   logic [15:0] numbers;
   logic [31:0] raw_segs;
   logic        raw_mode;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic [1:0]  brightness;
   logic [3:0]  LED_BITS;
   logic [7:0]  LED;
   logic        frame_tick;

   seg7_scan #(
      .DIGITS         (DIGITS),
      .PRESCALE       (PRESCALE),
      .BRIGHT_W       (BRIGHT_W),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .numbers    (numbers),
      .raw_segs   (raw_segs),
      .raw_mode   (raw_mode),
      .dp         (dp),
      .blank      (blank),
      .brightness (brightness),
`ifdef SEG7_BLINK_EN
      .blink      (4'b0000),
`endif
      .LED_BITS   (LED_BITS),
      .LED        (LED),
      .frame_tick (frame_tick)
   );

   // ------------------------------------------------------------ scoreboard
   int n_pass  = 0;
   int n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ------------------------------------------------------ reference model
   typedef struct packed {
      logic [15:0] num;
      logic [31:0] raw;
      logic        rm;
      logic [3:0]  dp;
      logic [3:0]  blank;
      logic [1:0]  br;
   } snap_t;

   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: return 8'h3F;  4'h1: return 8'h06;  4'h2: return 8'h5B;  4'h3: return 8'h4F;
         4'h4: return 8'h66;  4'h5: return 8'h6D;  4'h6: return 8'h7D;  4'h7: return 8'h07;
         4'h8: return 8'h7F;  4'h9: return 8'h6F;  4'hA: return 8'h77;  4'hB: return 8'h7C;
         4'hC: return 8'h39;  4'hD: return 8'h5E;  4'hE: return 8'h79;  default: return 8'h71;
      endcase
   endfunction

   function automatic snap_t cur_snap();
      return '{num: numbers, raw: raw_segs, rm: raw_mode, dp: dp, blank: blank, br: brightness};
   endfunction

   // Is the digit of time step k lit, given the frame's input set?
   function automatic bit model_lit(input int unsigned k, input snap_t s);
      int unsigned pre, dig;
      pre = k % PRESCALE;
      dig = (k / PRESCALE) % DIGITS;
      return !s.blank[dig] && (pre != 0) && ((pre % PWM_PER) <= s.br);
   endfunction

   function automatic logic [3:0] model_an(input int unsigned k, input snap_t s);
      int unsigned dig;
      dig = (k / PRESCALE) % DIGITS;
      if (model_lit(k, s)) return ~(4'b0001 << dig);
      return 4'hF;
   endfunction

   function automatic logic [7:0] model_led(input int unsigned k, input snap_t s);
      int unsigned dig;
      logic [7:0] pat;
      dig = (k / PRESCALE) % DIGITS;
      pat = s.rm ? s.raw[8*dig +: 8] : hex7(s.num[4*dig +: 4]);
      pat = pat | {s.dp[dig], 7'b0};
      if (model_lit(k, s)) return ~pat;
      return 8'hFF;
   endfunction

   // m_k counts edges since reset; the input set seen during step k was taken
   // on edge 1 (first frame) or on the edge that began the frame.
   int unsigned m_k;
   snap_t       m_snap;
   logic [3:0]  m_an;
   logic [7:0]  m_led;
   logic        m_tick;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_k    <= 0;
         m_snap <= '0;
         m_an   <= 4'hF;
         m_led  <= 8'hFF;
         m_tick <= 1'b0;
      end else begin
         m_an   <= model_an(m_k, m_snap);
         m_led  <= model_led(m_k, m_snap);
         m_tick <= ((m_k % FRAME) == FRAME - 1);
         m_k    <= m_k + 1;
         if (m_k == 0 || ((m_k + 1) % FRAME) == 0) m_snap <= cur_snap();
      end
   end

   // Cycle-by-cycle comparison against the model.
   bit chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("cyc_an", LED_BITS, m_an);
         check("cyc_led", LED, m_led);
         check("cyc_tick", frame_tick, m_tick);
         check("cyc_onehot", ($countones(~LED_BITS) <= 1), 1);
      end
   end

   // ------------------------------------------------------------ drivers
   task automatic set_inputs(input logic [15:0] n, input logic [31:0] r, input logic rm,
                             input logic [3:0] d, input logic [3:0] b, input logic [1:0] br);
      numbers    = n;
      raw_segs   = r;
      raw_mode   = rm;
      dp         = d;
      blank      = b;
      brightness = br;
   endtask

   task automatic wait_tick();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 4 * FRAME && !got; i++) begin
         @(negedge clk);
         if (frame_tick) got = 1'b1;
      end
      check("wait_tick", got, 1);
   endtask

   // Observe one frame of outputs (the 16 cycles after a frame_tick), counting
   // lit cycles per digit and keeping the first off-expectation segment value.
   int               fs_lit [4];
   logic [3:0][7:0]  fs_exp;
   logic [3:0][7:0]  fs_led;
   logic             fs_early;
   logic             fs_end;

   task automatic frame_scan(input bit do_wait, input int change_at, input logic [15:0] new_num);
      if (do_wait) wait_tick();
      for (int d = 0; d < DIGITS; d++) begin
         fs_lit[d] = 0;
         fs_led[d] = 8'h00;
      end
      fs_early = 1'b0;
      fs_end   = 1'b0;
      for (int c = 1; c <= FRAME; c++) begin
         @(negedge clk);
         if (c < FRAME) fs_early = fs_early | frame_tick;
         else           fs_end   = frame_tick;
         for (int d = 0; d < DIGITS; d++) begin
            if (!LED_BITS[d]) begin
               fs_lit[d]++;
               if (fs_lit[d] == 1 || fs_led[d] == fs_exp[d]) fs_led[d] = LED;
            end
         end
         if (c == change_at) numbers = new_num;
      end
   endtask

   task automatic frame_checks(input string tag, input logic [3:0][3:0] exp_lit);
      for (int d = 0; d < DIGITS; d++) begin
         check($sformatf("%s lit d%0d", tag, d), fs_lit[d], exp_lit[d]);
         if (exp_lit[d] != 0) check($sformatf("%s seg d%0d", tag, d), fs_led[d], fs_exp[d]);
      end
      check($sformatf("%s frame_len", tag), {fs_early, fs_end}, 2'b01);
   endtask

   // ------------------------------------------------------------ vectors
   typedef struct {
      string           name;
      logic [15:0]     num;
      logic [31:0]     raw;
      logic            rm;
      logic [3:0]      dp;
      logic [3:0]      blank;
      logic [1:0]      br;
      logic [3:0][7:0] led;   // pin-level pattern per digit while selected, {d3,d2,d1,d0}
      logic [3:0][3:0] lit;   // lit cycles per digit per frame, {d3,d2,d1,d0}
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{"n1234_b3",    16'h1234, 32'h0,         1'b0, 4'b0000, 4'b0000, 2'd3,
                  {8'hF9, 8'hA4, 8'hB0, 8'h99}, {4'd3, 4'd3, 4'd3, 4'd3}};
      vecs[1] = '{"n1234_b1",    16'h1234, 32'h0,         1'b0, 4'b0000, 4'b0000, 2'd1,
                  {8'hF9, 8'hA4, 8'hB0, 8'h99}, {4'd1, 4'd1, 4'd1, 4'd1}};
      vecs[2] = '{"blank1_dp0",  16'h1234, 32'h0,         1'b0, 4'b0001, 4'b0010, 2'd3,
                  {8'hF9, 8'hA4, 8'hFF, 8'h19}, {4'd3, 4'd3, 4'd0, 4'd3}};
      vecs[3] = '{"raw_ff",      16'h1234, 32'h0000_00FF, 1'b1, 4'b0000, 4'b0000, 2'd3,
                  {8'hFF, 8'hFF, 8'hFF, 8'h00}, {4'd3, 4'd3, 4'd3, 4'd3}};
      vecs[4] = '{"nA5C0_b2",    16'hA5C0, 32'h0,         1'b0, 4'b0000, 4'b0000, 2'd2,
                  {8'h88, 8'h92, 8'hC6, 8'hC0}, {4'd2, 4'd2, 4'd2, 4'd2}};
      vecs[5] = '{"nBDE9_dp",    16'hBDE9, 32'h0,         1'b0, 4'b1010, 4'b0000, 2'd3,
                  {8'h03, 8'hA1, 8'h06, 8'h90}, {4'd3, 4'd3, 4'd3, 4'd3}};
      vecs[6] = '{"n8F76_blk3",  16'h8F76, 32'h0,         1'b0, 4'b0000, 4'b1000, 2'd3,
                  {8'hFF, 8'h8E, 8'hF8, 8'h82}, {4'd0, 4'd3, 4'd3, 4'd3}};
      vecs[7] = '{"raw_mix_dp2", 16'hFFFF, 32'h8001_7F40, 1'b1, 4'b0100, 4'b0000, 2'd3,
                  {8'h7F, 8'h7E, 8'h80, 8'hBF}, {4'd3, 4'd3, 4'd3, 4'd3}};
   end

   // ------------------------------------------------------------ test
   initial begin
      set_inputs(16'h1234, 32'h0, 1'b0, 4'b0000, 4'b0000, 2'd3);
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      chk_en = 1'b1;
      repeat (3) @(negedge clk);
      check("reset an", LED_BITS, 4'hF);
      check("reset led", LED, 8'hFF);
      check("reset tick", frame_tick, 0);
      rst_n = 1'b1;

      // Fixed vectors, one full frame each.
      for (int v = 0; v < 8; v++) begin
         set_inputs(vecs[v].num, vecs[v].raw, vecs[v].rm, vecs[v].dp, vecs[v].blank, vecs[v].br);
         fs_exp = vecs[v].led;
         frame_scan(1'b1, -1, 16'h0);
         frame_checks(vecs[v].name, vecs[v].lit);
      end

      // Mid-frame change: the rest of the frame keeps the old numbers,
      // the next frame shows F on every digit.
      set_inputs(16'h1234, 32'h0, 1'b0, 4'b0000, 4'b0000, 2'd3);
      fs_exp = {8'hF9, 8'hA4, 8'hB0, 8'h99};
      frame_scan(1'b1, 6, 16'hFFFF);
      frame_checks("midframe_old", {4'd3, 4'd3, 4'd3, 4'd3});
      fs_exp = {8'h8E, 8'h8E, 8'h8E, 8'h8E};
      frame_scan(1'b0, -1, 16'h0);
      frame_checks("midframe_new", {4'd3, 4'd3, 4'd3, 4'd3});

      // Reset in the middle of digit 1's lit time, between clock edges.
      set_inputs(16'h1234, 32'h0, 1'b0, 4'b0000, 4'b0000, 2'd3);
      wait_tick();
      wait_tick();
      repeat (6) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst an", LED_BITS, 4'hF);
      check("async_rst led", LED, 8'hFF);
      check("async_rst tick", frame_tick, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("restart guard an", LED_BITS, 4'hF);
      @(negedge clk);
      check("restart d0 an", LED_BITS, 4'b1110);
      check("restart d0 led", LED, 8'h99);
      repeat (FRAME - 3) @(negedge clk);
      check("restart no early tick", frame_tick, 0);
      @(negedge clk);
      check("restart first tick", frame_tick, 1);

      // Randomized inputs, changed at arbitrary points within frames.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 7) == 0)
            set_inputs(16'($urandom), $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seg7_scan.md
Name: seg7_scan

Overview:
- Parametrised multiplexed 7-segment display driver; next generation of the board's fixed 8-digit scanner.
- Adds the following over the fixed scanner:
  - configurable digit count
  - prescaled scan rate
  - built-in hex decode or raw segment mode
  - per-digit blank and decimal point
  - PWM brightness
  - an anti-ghosting guard cycle
  - a frame-coherent input snapshot
- Sits between the MMIO display register file and the board anode/segment pins.

Parameters:
- DIGITS, 8: number of digits scanned; legal range 1..16.
- PRESCALE, 1024: clocks per digit slot; must be ≥ 2**BRIGHT_W and ≥ 2.
- BRIGHT_W, 4: width of the brightness control.
- SEG_ACTIVE_LOW, 1: 1 = segment outputs inverted at the pin (0 lights a segment).
- AN_ACTIVE_LOW, 1: 1 = anode outputs inverted at the pin (0 selects a digit).

Ports:
- clk, in, 1: system clock; all state on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- numbers, in, 4*DIGITS: hex nibble per digit; digit i = numbers[4i+:4].
- raw_segs, in, 8*DIGITS: raw segment byte per digit; digit i = raw_segs[8i+:8].
- raw_mode, in, 1: 1 = use raw_segs, 0 = decode numbers.
- dp, in, DIGITS: decimal point per digit.
- blank, in, DIGITS: 1 = digit i dark for its whole slot.
- brightness, in, BRIGHT_W: PWM duty; 0 = dimmest lit level, all-ones = full.
- LED_BITS, out, DIGITS: anode selects, registered.
- LED, out, 8: segments {dp,g,f,e,d,c,b,a}, bit0 = a, registered.
- frame_tick, out, 1: one-cycle pulse when a full scan frame completes.

Behaviour:
- Reset (async, rst_n=0):
  - pre_cnt=0, idx=0, snapshot registers cleared.
  - LED_BITS all inactive (all ones if AN_ACTIVE_LOW, else zeros).
  - LED all inactive (8'hFF if SEG_ACTIVE_LOW, else 8'h00).
  - frame_tick=0.
- Reset deassertion mid-scan restarts at digit 0, pre_cnt 0; no partial-frame state survives.
- Prescaler: pre_cnt counts 0..PRESCALE-1 and wraps. At pre_cnt==PRESCALE-1, idx advances; DIGITS-1 wraps to 0.
- frame_tick=1 for exactly the cycle after idx wraps DIGITS-1→0. With DIGITS=1 it fires every slot.
- Snapshot:
  - numbers, raw_segs, raw_mode, dp, blank and brightness are captured into shadow registers on the cycle idx wraps to 0, and on the first cycle after reset.
  - All digits in a frame therefore display one coherent value set.
  - Mid-frame input changes take effect at the next frame.
- Segment pattern (active-high, before polarity):
  - raw_mode=0: hex table 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
  - dp[idx] is ORed into bit7.
  - raw_mode=1: raw byte used as-is, with dp[idx] still ORed into bit7.
- Anode enable for slot idx is 1 only if all of the following hold:
  - blank[idx]=0;
  - pre_cnt≠0 (guard cycle, anti-ghosting);
  - (pre_cnt mod 2**BRIGHT_W) ≤ brightness.
- When the anode is disabled, LED is driven inactive too. No segment is ever driven while the anode is off.
- Output latency: LED/LED_BITS reflect (pre_cnt, idx) state with one cycle of registered delay. Only one anode is active at any time.
- Polarity: SEG_ACTIVE_LOW / AN_ACTIVE_LOW invert the final registered values.

Optional Feature:
- SEG7_BLINK_EN defined:
  - Adds input blink[DIGITS-1:0] (snapshotted with the others) and parameter BLINK_FRAMES (default 64).
  - A frame counter toggles a blink phase every BLINK_FRAMES frame_ticks.
  - While the phase is 1, digits with blink=1 behave as blanked.
  - The blink phase resets to 0.
- SEG7_BLINK_EN undefined: no blink port, no frame counter, identical to base behaviour.

Test Plan:
- Params DIGITS=4, PRESCALE=4, BRIGHT_W=2. Release rst_n, numbers=16'h1234, brightness=3 -> anodes cycle digit 0..3. Per slot: guard cycle dark, then 3 lit cycles. LED pattern (AL) = ~8'h66, ~8'h4F, ~8'h5B, ~8'h06 for digits 0..3. frame_tick pulses every 16 cycles.
- brightness=1 -> per 4-cycle slot the lit cycles are pre_cnt=1 only (pre_cnt=0 is the guard), so each digit is lit for 1 cycle.
- blank=4'b0010, dp=4'b0001 -> digit 1 never selected; digit 0 shows ~(8'h66|8'h80)=8'h19.
- raw_mode=1, raw_segs=32'h0000_00FF -> digit 0 LED=8'h00 (all segments lit), others 8'hFF while selected.
- Change numbers mid-frame to 16'hFFFF -> remaining digits of the current frame still show 1234 values. The next frame shows ~8'h71 on all digits.
- Assert rst_n low mid-slot -> LED_BITS=4'hF and LED=8'hFF in the same cycle, asynchronously. After release, scan restarts at digit 0.
